// File: rtl/log2_pkg.sv
// Shared types and helpers for the sequential base-2 logarithm unit.
package log2_pkg;

    // Controller states: wait for operand, square mantissa per bit, hold result.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Index width for a WIDTH-bit vector; never narrower than one bit.
    function automatic int iw_of(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/log2_msb_encoder.sv
// Combinational priority encoder: index of the highest set bit plus a zero flag.
module log2_msb_encoder
    import log2_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IW    = iw_of(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [IW-1:0]    msb,
    output logic             zero
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        msb  = '0;
        zero = (data == '0);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                msb = IW'(i);
            end
        end
    end

endmodule

// File: rtl/log2_seq.sv
// Sequential log2: integer part from the MSB index, fractional bits one per
// cycle by repeated squaring of the normalised 1.(WIDTH-1) mantissa.
module log2_seq
    import log2_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int FRAC_BITS = 4,
    localparam int IW        = iw_of(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_int,
    output logic [FRAC_BITS-1:0] out_frac,
    output logic                 out_error
);

    localparam int            CW       = iw_of(FRAC_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAC_BITS - 1);

    state_t                 state;
    logic [WIDTH-1:0]       m;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          int_r;
    logic [FRAC_BITS-1:0]   frac_r;

    logic [IW-1:0]          enc_msb;
    logic                   enc_zero;
    logic [IW-1:0]          shamt;
    logic [WIDTH-1:0]       norm;
    logic [2*WIDTH-1:0]     p;
    logic                   sq_bit;
    logic [WIDTH-1:0]       m_next;
    logic [FRAC_BITS-1:0]   frac_next;

    log2_msb_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .data (in_data),
        .msb  (enc_msb),
        .zero (enc_zero)
    );

    assign in_ready = (state == IDLE);

    // Normalise the operand and compute one squaring step of the mantissa.
    always_comb begin
        shamt  = IW'(WIDTH - 1) - enc_msb;
        norm   = in_data << shamt;
        p      = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, m};
        sq_bit = p[2*WIDTH-1];
        // p is 2.(2W-2); when p >= 2 the halved value is simply the top W bits.
        m_next    = sq_bit ? p[2*WIDTH-1 -: WIDTH] : p[2*WIDTH-2 -: WIDTH];
        // Shift in from the LSB side; the cast drops the oldest bit.
        frac_next = FRAC_BITS'({frac_r, sq_bit});
    end

    // Controller with registered result and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m         <= '0;
            cnt       <= '0;
            int_r     <= '0;
            frac_r    <= '0;
            out_valid <= 1'b0;
            out_int   <= '0;
            out_frac  <= '0;
            out_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (enc_zero) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_error <= 1'b1;
                            out_int   <= '0;
                            out_frac  <= '0;
                        end else begin
                            state  <= CALC;
                            int_r  <= enc_msb;
                            m      <= norm;
                            cnt    <= '0;
                            frac_r <= '0;
                        end
                    end
                end
                CALC: begin
                    m      <= m_next;
                    frac_r <= frac_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_int   <= int_r;
                        out_frac  <= frac_next;
                        out_error <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
